// File: rtl/repsub_divider.sv
// Unsigned divider using repeated subtraction. The dividend and the divisor arrive one after
// the other on a shared operand bus, and done pulses once when the result is ready.
module repsub_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadB,
    StCheck,
    StSub,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] r_sub;

  // Only used in StSub, where r_q >= d_q always holds, so it never wraps.
  assign r_sub = r_q - d_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          r_d     = data_in;
          q_d     = '0;
          dbz_d   = 1'b0;
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        d_d     = data_in;
        state_d = StCheck;
      end
      StCheck: begin
        if (d_q == '0) begin
          dbz_d   = 1'b1;
          state_d = StDone;
        end else if (r_q < d_q) begin
          state_d = StDone;
        end else begin
          state_d = StSub;
        end
      end
      StSub: begin
        r_d = r_sub;
        q_d = q_q + WIDTH'(1);
        if (r_sub < d_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == StDone);
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_repsub_divider.sv
// Bench for repsub_divider: an arithmetic reference model checks the outputs every cycle,
// and directed and random operations are applied on top of it.
module tb_repsub_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] quotient, remainder;
  logic        done, busy, div_by_zero;

  repsub_divider #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. m_c is the number of the cycle that follows the edge, counted from the
  // start cycle (cycle 0).
  bit m_valid = 0;
  bit m_active = 0;
  int m_c, m_done_at, m_a, m_b, m_q, m_r;
  bit m_dbz;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  = 1;
      m_active = 0;
      m_q      = 0;
      m_r      = 0;
      m_dbz    = 0;
    end else if (m_valid) begin
      if (!m_active) begin
        if (start) begin
          m_active  = 1;
          m_c       = 1;
          m_a       = int'(data_in);
          m_done_at = -1;
        end
      end else if (m_c == m_done_at) begin
        m_active = 0;
      end else begin
        m_c++;
        if (m_c == 2) begin
          m_b = int'(data_in);
          if (m_b == 0) begin
            m_q = 0; m_r = m_a; m_dbz = 1; m_done_at = 3;
          end else begin
            m_q = m_a / m_b; m_r = m_a % m_b; m_dbz = 0; m_done_at = 3 + m_q;
          end
        end
      end
    end
    if (m_valid) begin
      #1;
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {31'd0, done}, {31'd0, (m_active && m_c == m_done_at)});
      if (!m_active || m_c == m_done_at) begin
        check("quotient", {16'd0, quotient}, m_q);
        check("remainder", {16'd0, remainder}, m_r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
      end
    end
  end

  // Issues one division starting at the next negedge. lat is the number of the cycle in which
  // done was seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit noise,
                        output int lat);
    bit got;
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    @(negedge clk);
    start   = 1'b0;
    data_in = b;
    lat     = 1;
    got     = 0;
    while (lat < 70000) begin
      @(negedge clk);
      lat++;
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        data_in = 16'($urandom);
      end
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    start   = 1'b0;
    data_in = '0;
    check("done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
  endtask

  int lat;
  int n_done;
  int k;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_q", {16'd0, quotient}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    run_op(16'd100, 16'd7, 0, lat);
    check("lat_100_7", lat, 17);
    check("q_100_7", {16'd0, quotient}, 14);
    check("r_100_7", {16'd0, remainder}, 2);
    check("dbz_100_7", {31'd0, div_by_zero}, 0);

    run_op(16'd5, 16'd9, 0, lat);
    check("lat_5_9", lat, 3);
    check("q_5_9", {16'd0, quotient}, 0);
    check("r_5_9", {16'd0, remainder}, 5);

    run_op(16'h1234, 16'd0, 0, lat);
    check("lat_dz", lat, 3);
    check("dbz_dz", {31'd0, div_by_zero}, 1);
    check("q_dz", {16'd0, quotient}, 0);
    check("r_dz", {16'd0, remainder}, 32'h1234);

    run_op(16'd10, 16'd5, 0, lat);
    check("dbz_10_5", {31'd0, div_by_zero}, 0);
    check("q_10_5", {16'd0, quotient}, 2);
    check("r_10_5", {16'd0, remainder}, 0);

    run_op(16'd100, 16'd7, 1, lat);
    check("lat_noise", lat, 17);
    check("q_noise", {16'd0, quotient}, 14);
    check("r_noise", {16'd0, remainder}, 2);

    // Reset in cycle 8 of 100/7.
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'd100;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'd7;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_q", {16'd0, quotient}, 0);
    check("abort_r", {16'd0, remainder}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_dbz", {31'd0, div_by_zero}, 0);
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_op(16'd9, 16'd3, 0, lat);
    check("lat_9_3", lat, 6);
    check("q_9_3", {16'd0, quotient}, 3);
    check("r_9_3", {16'd0, remainder}, 0);

    // Random traffic; the model does all checking here.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 299) != 0);
      start   = ($urandom_range(0, 2) == 0);
      data_in = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 400));
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle", {31'd0, busy}, 0);

    run_op(16'hFFFF, 16'd1, 0, lat);
    check("lat_ffff_1", lat, 65538);
    check("q_ffff_1", {16'd0, quotient}, 32'hFFFF);
    check("r_ffff_1", {16'd0, remainder}, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
